// File: rtl/pwl_act_pkg.sv
// Shared constants for the piecewise-linear sigmoid/tanh unit.
// The tables are stored in Q5 and are scaled to the datapath's fractional width where they are used.
package pwl_act_pkg;

  localparam int SEG_N   = 9;
  localparam int BP_N    = SEG_N - 1;
  localparam int SEG_W   = 4;
  localparam int SH_W    = 4;
  localparam int Q5_FRAC = 5;

  localparam int BP_Q5 [BP_N]  = '{34, 69, 95, 119, 142, 165, 187, 232};
  localparam int B_Q5  [SEG_N] = '{16, 20, 25, 28, 29, 31, 31, 32, 32};
  // The last segment is flat (intercept only), so it has no shift entry.
  localparam int SH_Q5 [BP_N]  = '{2, 3, 4, 5, 6, 7, 8, 9};

  localparam logic MODE_SIG  = 1'b0;
  localparam logic MODE_TANH = 1'b1;

  function automatic int q5_scale(input int c, input int frac_w);
    return c << (frac_w - Q5_FRAC);
  endfunction

endpackage

// File: rtl/pwl_seg_lut.sv
// Segment lookup: finds the segment that holds magnitude m, and returns the
// intercept and slope shift of a segment that was registered earlier (seg_sel).
module pwl_seg_lut
  import pwl_act_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic [DATA_W-1:0] m,
  output logic [SEG_W-1:0]  seg,
  input  logic [SEG_W-1:0]  seg_sel,
  output logic [DATA_W-1:0] icpt,
  output logic [SH_W-1:0]   sh,
  output logic              use_slope
);

  logic [BP_N-1:0] below;

  for (genvar gi = 0; gi < BP_N; gi++) begin : g_bp
    localparam logic [DATA_W-1:0] BP_SCALED = DATA_W'(q5_scale(BP_Q5[gi], FRAC_W));
    assign below[gi] = (m < BP_SCALED);
  end

  // Breakpoints ascend, so the lowest set bit of below is the first breakpoint that m is under.
  always_comb begin
    seg = SEG_W'(BP_N);
    for (int i = BP_N - 1; i >= 0; i--) begin
      if (below[i]) seg = SEG_W'(i);
    end
  end

  always_comb begin
    icpt      = '0;
    sh        = '0;
    use_slope = 1'b0;
    for (int i = 0; i < SEG_N; i++) begin
      if (seg_sel == SEG_W'(i)) icpt = DATA_W'(q5_scale(B_Q5[i], FRAC_W));
    end
    for (int i = 0; i < BP_N; i++) begin
      if (seg_sel == SEG_W'(i)) begin
        sh        = SH_W'(SH_Q5[i]);
        use_slope = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwl_act_pipe.sv
// Three-stage piecewise-linear sigmoid/tanh unit with a valid/ready handshake.
// Stage 1 computes the magnitude, stage 2 finds the segment, stage 3 evaluates the segment and applies the mode.
module pwl_act_pipe
  import pwl_act_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_sat
);

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1) << FRAC_W;

  logic en;

  logic              v1_q, v1_d, mode1_q, mode1_d, sign1_q, sign1_d, sat1_q, sat1_d;
  logic [TAG_W-1:0]  tag1_q, tag1_d;
  logic [DATA_W-1:0] m1_q, m1_d;

  logic              v2_q, v2_d, mode2_q, mode2_d, sign2_q, sign2_d, sat2_q, sat2_d;
  logic [TAG_W-1:0]  tag2_q, tag2_d;
  logic [DATA_W-1:0] m2_q, m2_d;
  logic [SEG_W-1:0]  seg2_q, seg2_d;

  logic              out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

  logic [DATA_W:0]   dbl;
  logic [DATA_W-1:0] a_val, m_calc;
  logic              a_clip, sat_calc;

  logic [SEG_W-1:0]  lut_seg;
  logic [DATA_W-1:0] lut_icpt;
  logic [SH_W-1:0]   lut_sh;
  logic              lut_use_slope;
  logic [DATA_W-1:0] slope, s_val, sig, res;

  // A single stall for the whole pipe: every stage advances only when the output slot can move.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Stage 1: optional doubling with saturation, then magnitude.
  always_comb begin
    dbl    = {in_data, 1'b0};
    a_val  = in_data;
    a_clip = 1'b0;
    if (in_mode == MODE_TANH) begin
      if (dbl[DATA_W] != dbl[DATA_W-1]) begin
        a_val  = dbl[DATA_W] ? MIN_NEG : MAX_POS;
        a_clip = 1'b1;
      end else begin
        a_val  = dbl[DATA_W-1:0];
      end
    end
    if (a_val == MIN_NEG) begin
      m_calc   = MAX_POS;
      sat_calc = 1'b1;
    end else begin
      m_calc   = a_val[DATA_W-1] ? (DATA_W'(0) - a_val) : a_val;
      sat_calc = a_clip;
    end
  end

  pwl_seg_lut #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_lut (
    .m         (m1_q),
    .seg       (lut_seg),
    .seg_sel   (seg2_q),
    .icpt      (lut_icpt),
    .sh        (lut_sh),
    .use_slope (lut_use_slope)
  );

  // Stage 3: results always fit DATA_W, so modulo-2^DATA_W arithmetic equals the wider form truncated.
  always_comb begin
    slope = lut_use_slope ? (m2_q >> lut_sh) : '0;
    s_val = lut_icpt + slope;
    sig   = sign2_q ? (ONE - s_val) : s_val;
    res   = (mode2_q == MODE_TANH) ? ((sig << 1) - ONE) : sig;
  end

  always_comb begin
    v1_d        = v1_q;
    mode1_d     = mode1_q;
    tag1_d      = tag1_q;
    sign1_d     = sign1_q;
    m1_d        = m1_q;
    sat1_d      = sat1_q;
    v2_d        = v2_q;
    mode2_d     = mode2_q;
    tag2_d      = tag2_q;
    sign2_d     = sign2_q;
    m2_d        = m2_q;
    sat2_d      = sat2_q;
    seg2_d      = seg2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_sat_d   = out_sat_q;
    if (en) begin
      v1_d        = in_valid;
      mode1_d     = in_mode;
      tag1_d      = in_tag;
      sign1_d     = in_data[DATA_W-1];
      m1_d        = m_calc;
      sat1_d      = sat_calc;
      v2_d        = v1_q;
      mode2_d     = mode1_q;
      tag2_d      = tag1_q;
      sign2_d     = sign1_q;
      m2_d        = m1_q;
      sat2_d      = sat1_q;
      seg2_d      = lut_seg;
      out_valid_d = v2_q;
      out_data_d  = res;
      out_tag_d   = tag2_q;
      out_sat_d   = sat2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      mode1_q     <= 1'b0;
      tag1_q      <= '0;
      sign1_q     <= 1'b0;
      m1_q        <= '0;
      sat1_q      <= 1'b0;
      v2_q        <= 1'b0;
      mode2_q     <= 1'b0;
      tag2_q      <= '0;
      sign2_q     <= 1'b0;
      m2_q        <= '0;
      sat2_q      <= 1'b0;
      seg2_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      mode1_q     <= mode1_d;
      tag1_q      <= tag1_d;
      sign1_q     <= sign1_d;
      m1_q        <= m1_d;
      sat1_q      <= sat1_d;
      v2_q        <= v2_d;
      mode2_q     <= mode2_d;
      tag2_q      <= tag2_d;
      sign2_q     <= sign2_d;
      m2_q        <= m2_d;
      sat2_q      <= sat2_d;
      seg2_q      <= seg2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_sat   = out_sat_q;

endmodule
